trivium_stream_core: RTL and testbench



---
 rtl/trivium_pkg.sv | 62 ++++++
 rtl/trivium_round_unroll.sv | 40 ++++
 rtl/trivium_stream_core.sv | 153 +++++++++++++++
 tb/tb_trivium_stream_core.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: widths, tap positions, FSM state encoding and
// the key/IV load-value builder. State bit s(k) of the textbook description is
// stored at vector index k-1. The encoding gains a CLEAR state when
// TRIVIUM_ZEROIZE_EN is defined.
package trivium_pkg;

    localparam int STATE_W = 288;
    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;

    // Start of the second (s94..s177) and third (s178..s288) shift registers
    localparam int REG_B_BASE = 93;
    localparam int REG_C_BASE = 177;

    // Linear taps
    localparam int T1_A = 65;
    localparam int T1_B = 92;
    localparam int T2_A = 161;
    localparam int T2_B = 176;
    localparam int T3_A = 242;
    localparam int T3_B = 287;

    // Nonlinear AND taps and the cross-register feed taps
    localparam int T1_AND_A = 90;
    localparam int T1_AND_B = 91;
    localparam int T1_X     = 170;
    localparam int T2_AND_A = 174;
    localparam int T2_AND_B = 175;
    localparam int T2_X     = 263;
    localparam int T3_AND_A = 285;
    localparam int T3_AND_B = 286;
    localparam int T3_X     = 68;

`ifdef TRIVIUM_ZEROIZE_EN
    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        CLEAR
    } core_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } core_state_t;
`endif

    // Key in s1..s80, IV in s94..s173, s286..s288 set, everything else zero
    function automatic logic [STATE_W-1:0] trivium_init(
        input logic [KEY_W-1:0] key,
        input logic [IV_W-1:0]  iv
    );
        logic [STATE_W-1:0] s;
        s = '0;
        s[KEY_W-1:0] = key;
        s[REG_B_BASE +: IV_W] = iv;
        s[STATE_W-1 -: 3] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round_unroll.sv
// Combinational N-round Trivium step: returns the state after N rounds and
// the N keystream bits, bit j being the output of round j.
module trivium_round_unroll
    import trivium_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [STATE_W-1:0] cur_state,
    output logic [STATE_W-1:0] next_state,
    output logic [N-1:0]       z
);

    logic [STATE_W-1:0] s;
    logic               t1;
    logic               t2;
    logic               t3;

    // Chain N standard Trivium rounds, collecting each round's output bit
    always_comb begin
        s  = cur_state;
        z  = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int j = 0; j < N; j++) begin
            t1 = s[T1_A] ^ s[T1_B];
            t2 = s[T2_A] ^ s[T2_B];
            t3 = s[T3_A] ^ s[T3_B];
            z[j] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[T1_AND_A] & s[T1_AND_B]) ^ s[T1_X];
            t2 = t2 ^ (s[T2_AND_A] & s[T2_AND_B]) ^ s[T2_X];
            t3 = t3 ^ (s[T3_AND_A] & s[T3_AND_B]) ^ s[T3_X];
            s = {s[STATE_W-2:REG_C_BASE], t2,
                 s[REG_C_BASE-2:REG_B_BASE], t1,
                 s[REG_B_BASE-2:0], t3};
        end
        next_state = s;
    end

endmodule

// File: rtl/trivium_stream_core.sv
// Trivium keystream core: run-time key/IV load, internal warm-up, then one
// WORD_W-bit keystream word per clock on a valid/ready stream.
// Optional macro TRIVIUM_ZEROIZE_EN: blanks ks_data while invalid and wipes the
// cipher state for one cycle before a rekey issued from RUN.
module trivium_stream_core
    import trivium_pkg::*;
#(
    parameter int WORD_W      = 8,
    parameter int INIT_ROUNDS = 1152
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [IV_W-1:0]   iv_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic              busy
);

    localparam int WARM_CYCLES = INIT_ROUNDS / WORD_W;
    localparam int CNT_W       = $clog2(WARM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_CYCLES - 1);

    core_state_t        fsm_q;
    core_state_t        fsm_d;
    logic [STATE_W-1:0] cipher_q;
    logic [STATE_W-1:0] cipher_d;
    logic [STATE_W-1:0] cipher_adv;
    logic [WORD_W-1:0]  word_z;
    logic [WORD_W-1:0]  data_q;
    logic [WORD_W-1:0]  data_d;
    logic               valid_q;
    logic               valid_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

`ifdef TRIVIUM_ZEROIZE_EN
    logic [KEY_W-1:0]   key_hold_q;
    logic [KEY_W-1:0]   key_hold_d;
    logic [IV_W-1:0]    iv_hold_q;
    logic [IV_W-1:0]    iv_hold_d;
`endif

    trivium_round_unroll #(
        .N (WORD_W)
    ) u_unroll (
        .cur_state  (cipher_q),
        .next_state (cipher_adv),
        .z          (word_z)
    );

    // Next-state logic: load, warm-up counting, stream advance under back-pressure
    always_comb begin
        fsm_d      = fsm_q;
        cipher_d   = cipher_q;
        data_d     = data_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        busy       = 1'b0;
`ifdef TRIVIUM_ZEROIZE_EN
        key_hold_d = key_hold_q;
        iv_hold_d  = iv_hold_q;
`endif
        case (fsm_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    cipher_d = trivium_init(key_in, iv_in);
                    cnt_d    = '0;
                    fsm_d    = WARMUP;
                end
            end
            WARMUP: begin
                busy     = 1'b1;
                cipher_d = cipher_adv;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    fsm_d   = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
`ifdef TRIVIUM_ZEROIZE_EN
                    cipher_d   = '0;
                    key_hold_d = key_in;
                    iv_hold_d  = iv_in;
                    fsm_d      = CLEAR;
`else
                    cipher_d = trivium_init(key_in, iv_in);
                    fsm_d    = WARMUP;
`endif
                end else if (!valid_q || ks_ready) begin
                    cipher_d = cipher_adv;
                    data_d   = word_z;
                    valid_d  = 1'b1;
                end
            end
`ifdef TRIVIUM_ZEROIZE_EN
            CLEAR: begin
                cipher_d = trivium_init(key_hold_q, iv_hold_q);
                cnt_d    = '0;
                fsm_d    = WARMUP;
            end
`endif
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to an empty, idle core
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            cipher_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef TRIVIUM_ZEROIZE_EN
            key_hold_q <= '0;
            iv_hold_q  <= '0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            cipher_q <= cipher_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
`ifdef TRIVIUM_ZEROIZE_EN
            key_hold_q <= key_hold_d;
            iv_hold_q  <= iv_hold_d;
`endif
        end
    end

    assign ks_valid = valid_q;
`ifdef TRIVIUM_ZEROIZE_EN
    assign ks_data = valid_q ? data_q : '0;
`else
    assign ks_data = data_q;
`endif

endmodule

// File: tb/tb_trivium_stream_core.sv
// Self-checking bench for trivium_stream_core: table-driven loads at WORD_W=8,
// hand-written rekey and mid-warm-up reset sequences, and a cross-width
// comparison at WORD_W=1 and WORD_W=64 against a bit-serial Trivium model.
// Honours TRIVIUM_ZEROIZE_EN for the rekey latency and blanked-data checks.
module tb_trivium_stream_core;

    localparam int W         = 8;
    localparam int WARM      = 1152 / W;
    localparam int FIRST_LAT = WARM + 1;
`ifdef TRIVIUM_ZEROIZE_EN
    localparam int REKEY_LAT = WARM + 2;
`else
    localparam int REKEY_LAT = WARM + 1;
`endif
    localparam logic [79:0] KT = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] IT = 80'hECBB76B09AFF71D0D151;
    localparam logic [79:0] KB = 80'h0123456789ABCDEF0011;
    localparam logic [79:0] IB = 80'hFEDCBA98765432100FF0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [79:0]  key_in = '0;
    logic [79:0]  iv_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] ks_data;
    logic         ks_valid;
    logic         ks_ready = 1'b0;
    logic         busy;

    logic         w1_load_valid = 1'b0;
    logic         w1_load_ready;
    logic [0:0]   w1_ks_data;
    logic         w1_ks_valid;
    logic         w1_ks_ready = 1'b0;
    logic         w1_busy;

    logic         w64_load_valid = 1'b0;
    logic         w64_load_ready;
    logic [63:0]  w64_ks_data;
    logic         w64_ks_valid;
    logic         w64_ks_ready = 1'b0;
    logic         w64_busy;

    int vec_count  = 0;
    int miss_count = 0;

    logic [63:0] sb[$];
    logic [63:0] sb_w1[$];
    logic [63:0] sb_w64[$];

    // Reference model kept as the three textbook registers A, B, C
    logic [1:93]  ma;
    logic [1:84]  mb;
    logic [1:111] mc;

    typedef struct {
        logic [79:0] key;
        logic [79:0] iv;
        int          nwords;
        bit          rand_ready;
        int          exp_latency;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    trivium_stream_core #(.WORD_W(W), .INIT_ROUNDS(1152)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in),
        .load_valid(load_valid), .load_ready(load_ready),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
    );

    trivium_stream_core #(.WORD_W(1), .INIT_ROUNDS(1152)) dut_w1 (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in),
        .load_valid(w1_load_valid), .load_ready(w1_load_ready),
        .ks_data(w1_ks_data), .ks_valid(w1_ks_valid), .ks_ready(w1_ks_ready), .busy(w1_busy)
    );

    trivium_stream_core #(.WORD_W(64), .INIT_ROUNDS(1152)) dut_w64 (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in),
        .load_valid(w64_load_valid), .load_ready(w64_load_ready),
        .ks_data(w64_ks_data), .ks_valid(w64_ks_valid), .ks_ready(w64_ks_ready), .busy(w64_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelStep(output logic z);
        logic t1, t2, t3;
        t1 = ma[66] ^ ma[93];
        t2 = mb[69] ^ mb[84];
        t3 = mc[66] ^ mc[111];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ma[91] & ma[92]) ^ mb[78];
        t2 = t2 ^ (mb[82] & mb[83]) ^ mc[87];
        t3 = t3 ^ (mc[109] & mc[110]) ^ ma[69];
        ma = {t3, ma[1:92]};
        mb = {t1, mb[1:83]};
        mc = {t2, mc[1:110]};
    endtask

    task automatic modelLoad(input logic [79:0] key, input logic [79:0] iv);
        logic z;
        ma = '0;
        mb = '0;
        mc = '0;
        for (int i = 0; i < 80; i++) begin
            ma[i+1] = key[i];
            mb[i+1] = iv[i];
        end
        mc[109] = 1'b1;
        mc[110] = 1'b1;
        mc[111] = 1'b1;
        for (int r = 0; r < 1152; r++) modelStep(z);
    endtask

    task automatic modelWord(input int w, output logic [63:0] word);
        logic b;
        word = '0;
        for (int j = 0; j < w; j++) begin
            modelStep(b);
            word[j] = b;
        end
    endtask

    task automatic pushModel(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            modelWord(W, w);
            sb.push_back(w);
        end
    endtask

    task automatic checkZeroize;
`ifdef TRIVIUM_ZEROIZE_EN
        if (!ks_valid) checkOutput("zeroize_data", 64'(ks_data), 64'd0);
`endif
    endtask

    task automatic checkResetValues;
        checkOutput("reset_ks_valid", 64'(ks_valid), 64'd0);
        checkOutput("reset_ks_data", 64'(ks_data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_load_ready", 64'(load_ready), 64'd1);
    endtask

    task automatic doReset;
        rst = 1'b1;
        load_valid = 1'b0;
        w1_load_valid = 1'b0;
        w64_load_valid = 1'b0;
        ks_ready = 1'b0;
        tick();
        tick();
        checkResetValues();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [79:0] key, input logic [79:0] iv);
        key_in = key;
        iv_in = iv;
        load_valid = 1'b1;
        checkOutput("load_ready_at_load", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic waitFirstValid(input int exp_lat);
        int lat = 0;
        int busy_cnt = 0;
        while (!ks_valid && lat < exp_lat + 20) begin
            if (busy && !load_ready) busy_cnt++;
            checkZeroize();
            tick();
            lat++;
        end
        checkOutput("first_valid_latency", 64'(lat), 64'(exp_lat));
        checkOutput("warmup_busy_cycles", 64'(busy_cnt), 64'(WARM));
    endtask

    task automatic runStream(input int nwords, input bit rand_ready, input string tag);
        int got = 0;
        int budget = 0;
        logic stall_prev = 1'b0;
        logic [W-1:0] data_prev = '0;
        while (got < nwords && budget < nwords * 4 + 50) begin
            ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_prev) begin
                checkOutput("stall_valid", 64'(ks_valid), 64'd1);
                checkOutput("stall_data", 64'(ks_data), 64'(data_prev));
            end
            checkZeroize();
            if (ks_valid && ks_ready) begin
                checkOutput(tag, 64'(ks_data), sb.pop_front());
                got++;
            end
            stall_prev = ks_valid && !ks_ready;
            data_prev = ks_data;
            tick();
            budget++;
        end
        checkOutput("words_received", 64'(got), 64'(nwords));
    endtask

    // Two widths loaded together; their streams are checked against one model bitstream
    task automatic runWideCompare;
        logic [63:0] w;
        logic [63:0] acc = '0;
        int c = 0, n1 = 0, words1 = 0, words64 = 0;
        int first1 = -1, first64 = -1;
        doReset();
        modelLoad(KT, IT);
        sb_w1.delete();
        sb_w64.delete();
        for (int i = 0; i < 64; i++) begin
            modelWord(64, w);
            sb_w1.push_back(w);
            sb_w64.push_back(w);
        end
        key_in = KT;
        iv_in = IT;
        w1_load_valid = 1'b1;
        w64_load_valid = 1'b1;
        w1_ks_ready = 1'b1;
        w64_ks_ready = 1'b1;
        tick();
        w1_load_valid = 1'b0;
        w64_load_valid = 1'b0;
        while ((words1 < 64 || words64 < 64) && c < 7000) begin
            if (w1_ks_valid && first1 < 0) first1 = c;
            if (w64_ks_valid && first64 < 0) first64 = c;
            if (w1_ks_valid && w1_ks_ready && words1 < 64) begin
                acc[n1] = w1_ks_data[0];
                n1++;
                if (n1 == 64) begin
                    checkOutput("w1_chunk", acc, sb_w1.pop_front());
                    words1++;
                    n1 = 0;
                end
            end
            if (w64_ks_valid && w64_ks_ready && words64 < 64) begin
                checkOutput("w64_word", w64_ks_data, sb_w64.pop_front());
                words64++;
            end
            tick();
            c++;
        end
        checkOutput("w1_first_valid", 64'(first1), 64'd1153);
        checkOutput("w64_first_valid", 64'(first64), 64'd19);
        checkOutput("w1_chunks_received", 64'(words1), 64'd64);
        checkOutput("w64_words_received", 64'(words64), 64'd64);
    endtask

    initial begin
        vecs[0] = '{key: 80'h0, iv: 80'h0, nwords: 64, rand_ready: 1'b0, exp_latency: FIRST_LAT};
        vecs[1] = '{key: KT, iv: IT, nwords: 64, rand_ready: 1'b0, exp_latency: FIRST_LAT};
        vecs[2] = '{key: {80{1'b1}}, iv: 80'h00112233445566778899, nwords: 1000, rand_ready: 1'b1, exp_latency: FIRST_LAT};
        vecs[3] = '{key: KB, iv: IB, nwords: 32, rand_ready: 1'b0, exp_latency: FIRST_LAT};

        for (int i = 0; i < 4; i++) begin
            doReset();
            modelLoad(vecs[i].key, vecs[i].iv);
            sb.delete();
            pushModel(vecs[i].nwords);
            applyStimulus(vecs[i].key, vecs[i].iv);
            waitFirstValid(vecs[i].exp_latency);
            runStream(vecs[i].nwords, vecs[i].rand_ready, "keystream_word");
        end

        // Rekey while a word is pending and the consumer is stalled: word is dropped
        doReset();
        modelLoad(KT, IT);
        sb.delete();
        pushModel(8);
        applyStimulus(KT, IT);
        waitFirstValid(FIRST_LAT);
        runStream(4, 1'b0, "pre_rekey_word");
        ks_ready = 1'b0;
        tick();
        checkOutput("pending_valid", 64'(ks_valid), 64'd1);
        checkOutput("pending_word", 64'(ks_data), sb[0]);
        tick();
        checkOutput("pending_word_held", 64'(ks_data), sb[0]);
        modelLoad(KB, IB);
        sb.delete();
        pushModel(16);
        key_in = KB;
        iv_in = IB;
        load_valid = 1'b1;
        checkOutput("rekey_load_ready", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        checkOutput("rekey_drop_valid", 64'(ks_valid), 64'd0);
        waitFirstValid(REKEY_LAT);
        runStream(16, 1'b0, "rekey_word");

        // Rekey in the same cycle the pending word is taken: that word counts as consumed
        doReset();
        modelLoad(KT, IT);
        sb.delete();
        pushModel(8);
        applyStimulus(KT, IT);
        waitFirstValid(FIRST_LAT);
        runStream(4, 1'b0, "pre_rekey_word");
        key_in = KB;
        iv_in = IB;
        load_valid = 1'b1;
        ks_ready = 1'b1;
        checkOutput("rekey_valid_before", 64'(ks_valid), 64'd1);
        checkOutput("rekey_consumed_word", 64'(ks_data), sb.pop_front());
        modelLoad(KB, IB);
        sb.delete();
        pushModel(16);
        tick();
        load_valid = 1'b0;
        checkOutput("rekey_after_consume_valid", 64'(ks_valid), 64'd0);
        waitFirstValid(REKEY_LAT);
        runStream(16, 1'b0, "rekey_word");

        // Reset in the middle of warm-up, then a fresh load
        doReset();
        applyStimulus(KB, IB);
        repeat (70) tick();
        checkOutput("midwarm_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        checkResetValues();
        rst = 1'b0;
        modelLoad(KB, IB);
        sb.delete();
        pushModel(16);
        applyStimulus(KB, IB);
        waitFirstValid(FIRST_LAT);
        runStream(16, 1'b0, "post_reset_word");

        runWideCompare();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
